// File: rtl/lsu_ctrl_if.sv
// Execute-stage request/response channel and data-memory bus of the load/store unit.
// The slave modport is the LSU itself; the master modport is its environment.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_misaligned;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: one outstanding request, byte/half/word/dword loads with extension,
// and read-modify-write for sub-doubleword stores on a doubleword-only memory.
module lsu_ctrl #(
  parameter int ADDR_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic        st_write;
  logic [1:0]  st_size;
  logic        st_unsigned;
  logic [2:0]  st_off;
  logic [63:0] st_wdata;
  logic        misaligned;

  always_comb begin
    unique case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase
  end

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    unique case (size)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] d, input logic [2:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [63:0] s;
    s = d >> {off, 3'b000};
    unique case (size)
      2'b00:   return uns ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
      2'b01:   return uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'b10:   return uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  // Replace the addressed lane of the old doubleword with the low bytes of the store data.
  function automatic logic [63:0] merge(input logic [63:0] d, input logic [63:0] w,
                                        input logic [2:0] off, input logic [1:0] size);
    logic [63:0] lane;
    lane = size_mask(size) << {off, 3'b000};
    return (d & ~lane) | ((w & size_mask(size)) << {off, 3'b000});
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      st_write            <= 1'b0;
      st_size             <= '0;
      st_unsigned         <= 1'b0;
      st_off              <= '0;
      st_wdata            <= '0;
      bus.req_ready       <= 1'b1;
      bus.resp_valid      <= 1'b0;
      bus.resp_rdata      <= '0;
      bus.resp_misaligned <= 1'b0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            st_write      <= bus.req_write;
            st_size       <= bus.req_size;
            st_unsigned   <= bus.req_unsigned;
            st_off        <= bus.req_addr[2:0];
            st_wdata      <= bus.req_wdata;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
            if (misaligned) begin
              state               <= ERR;
              bus.resp_valid      <= 1'b1;
              bus.resp_misaligned <= 1'b1;
              bus.resp_rdata      <= '0;
            end else if (bus.req_write && bus.req_size == 2'b11) begin
              state         <= WR;
              bus.mem_write <= 1'b1;
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state        <= RD;
              bus.mem_read <= 1'b1;
            end
          end
        end
        // mem_rdata is only trusted on the final read cycle.
        RD: begin
          if (cnt == LAST_CNT) begin
            bus.mem_read <= 1'b0;
            if (st_write) begin
              state         <= WR;
              bus.mem_write <= 1'b1;
              bus.mem_wdata <= merge(bus.mem_rdata, st_wdata, st_off, st_size);
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= extract(bus.mem_rdata, st_off, st_size, st_unsigned);
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        WR: begin
          state          <= RESP;
          bus.mem_write  <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
        end
        RESP, ERR: begin
          state               <= IDLE;
          bus.req_ready       <= 1'b1;
          bus.resp_valid      <= 1'b0;
          bus.resp_misaligned <= 1'b0;
          bus.resp_rdata      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
